int_ctrl: RTL and testbench

- Interrupt controller that sequences the special-purpose register file (SPR) on every interrupt.
- Collects internal cause lines from the executing instruction and the external interrupt lines, and applies the SR mask.
- At instruction boundaries, decides whether to fire the one-cycle jisr strobe; drives the masked cause vector (mca), the repeat flag (rpt) and the pending interrupt level (il) that the SPR file captures.
- Tracks user vs handler context and the return-from-exception (rfe) path.
- Sits between the execute stage and the SPR file; also supplies the handler redirect PC to the fetch stage.

---
 rtl/int_ctrl_pkg.sv | 33 +++
 rtl/int_ctrl_prio.sv | 32 +++
 rtl/int_ctrl.sv | 171 +++++++++++++++++
 tb/tb_int_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Holds the cause index map, the default mask/repeat/entry constants and
// the controller state encoding. Imported by int_ctrl and its encoder.
package int_ctrl_pkg;

    // Number of cause lines and width of an encoded cause index.
    localparam int N_INT_DEF = 23;
    localparam int IL_W      = 5;

    // Cause indices. Lower index means higher priority.
    localparam int CAUSE_RST  = 0;
    localparam int CAUSE_ILL  = 1;
    localparam int CAUSE_MAL  = 2;
    localparam int CAUSE_PFF  = 3;
    localparam int CAUSE_PFLS = 4;
    localparam int CAUSE_TRAP = 5;
    localparam int CAUSE_OVF  = 6;
    localparam int CAUSE_EXT0 = 7;

    // Causes 0..5 cannot be masked; page faults are repeat type.
    localparam logic [N_INT_DEF-1:0] MASKABLE_DEF  = 23'h7F_FFC0;
    localparam logic [N_INT_DEF-1:0] REPEAT_DEF    = 23'h00_0018;
    localparam logic [31:0]          SISR_ADDR_DEF = 32'h0000_0000;

    // Controller states.
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_JISR = 2'd2,
        ST_HND  = 2'd3
    } state_t;

endpackage

// File: rtl/int_ctrl_prio.sv
// Lowest-set-bit encoder.
// Ports:
//   vec - request vector, bit 0 has the highest priority
//   idx - index of the lowest set bit of vec (0 when vec is empty)
//   any - at least one bit of vec is set
module prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = N_INT_DEF,
    parameter int W = IL_W
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = {W{1'b0}};
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end else begin
                idx = idx;
                any = any;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller sequencing the SPR file on every interrupt.
// Gathers instruction causes and sticky external lines, applies the SR
// mask at instruction boundaries and fires a one-cycle jisr strobe with
// the cause vector, repeat flag and level captured by the SPR file.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   instr_valid   - instruction boundary; qualifies cause_int, ovf, rfe
//   cause_int     - internal causes [5:1] (bit 0 unused)
//   ovf           - arithmetic overflow (cause 6)
//   ext_int       - external level lines, causes 22..7
//   sr            - status register mask bits
//   rfe           - completing instruction is return-from-exception
//   jisr          - one-cycle interrupt strobe
//   mca, rpt, il  - masked causes, repeat flag, lowest cause index
//   busy          - pipeline must hold
//   in_handler    - handler context
//   redirect_pc   - handler entry address
//   ext_ack       - external lines consumed, aligned with jisr
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                N_INT     = N_INT_DEF,
    parameter logic [N_INT-1:0]  MASKABLE  = MASKABLE_DEF,
    parameter logic [N_INT-1:0]  REPEAT    = REPEAT_DEF,
    parameter logic [31:0]       SISR_ADDR = SISR_ADDR_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        instr_valid,
    input  logic [5:0]                  cause_int,
    input  logic                        ovf,
    input  logic [N_INT-CAUSE_EXT0-1:0] ext_int,
    input  logic [N_INT-1:0]            sr,
    input  logic                        rfe,
    output logic                        jisr,
    output logic [N_INT-1:0]            mca,
    output logic                        rpt,
    output logic [IL_W-1:0]             il,
    output logic                        busy,
    output logic                        in_handler,
    output logic [31:0]                 redirect_pc,
    output logic [N_INT-CAUSE_EXT0-1:0] ext_ack
);

    localparam int N_EXT = N_INT - CAUSE_EXT0;

    state_t           state_r;
    state_t           state_nxt;
    logic [N_EXT-1:0] pend_r;
    logic [N_INT-1:0] ca_s;
    logic [N_INT-1:0] m_s;
    logic [N_INT-1:0] lowest_s;
    logic [IL_W-1:0]  il_s;
    logic             fire_s;
    logic             rpt_s;
    logic [N_INT-1:0] mca_r;
    logic [N_INT-1:0] mca_nxt;
    logic [IL_W-1:0]  il_r;
    logic [IL_W-1:0]  il_nxt;
    logic             rpt_r;
    logic             rpt_nxt;
    logic             jisr_r;
    logic             busy_r;
    logic             in_handler_r;
    logic [N_EXT-1:0] ext_ack_r;

    // Raw cause vector. Instruction causes count only at a boundary;
    // cause_int[0] is a reserved tie-off and is forced to zero here.
    assign ca_s = {pend_r | ext_int,
                   ovf & instr_valid,
                   cause_int[5:1] & {5{instr_valid}},
                   cause_int[0] & 1'b0};

    // Maskable causes pass only with their sr bit set.
    assign m_s = ca_s & (~MASKABLE | sr);

    prio_enc #(
        .N (N_INT),
        .W (IL_W)
    ) u_prio (
        .vec (m_s),
        .idx (il_s),
        .any (fire_s)
    );

    // Only the highest-priority cause decides the repeat flag.
    assign lowest_s = m_s & (~m_s + N_INT'(1));
    assign rpt_s    = |(lowest_s & REPEAT);

    // Next-state and next capture values for the SPR interface.
    always_comb begin
        state_nxt = state_r;
        mca_nxt   = mca_r;
        il_nxt    = il_r;
        rpt_nxt   = rpt_r;
        case (state_r)
            ST_RST: begin
                state_nxt = ST_JISR;
                mca_nxt   = N_INT'(1);
                il_nxt    = {IL_W{1'b0}};
                rpt_nxt   = 1'b0;
            end
            ST_RUN: begin
                if (instr_valid && fire_s) begin
                    state_nxt = ST_JISR;
                    mca_nxt   = m_s;
                    il_nxt    = il_s;
                    rpt_nxt   = rpt_s;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_JISR: begin
                state_nxt = ST_HND;
            end
            ST_HND: begin
                // A cause on the rfe instruction wins over the return.
                if (instr_valid && fire_s) begin
                    state_nxt = ST_JISR;
                    mca_nxt   = m_s;
                    il_nxt    = il_s;
                    rpt_nxt   = rpt_s;
                end else if (instr_valid && rfe) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_HND;
                end
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    // State, capture registers and registered outputs derived from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_RST;
            pend_r       <= {N_EXT{1'b0}};
            mca_r        <= {N_INT{1'b0}};
            il_r         <= {IL_W{1'b0}};
            rpt_r        <= 1'b0;
            jisr_r       <= 1'b0;
            busy_r       <= 1'b1;
            in_handler_r <= 1'b0;
            ext_ack_r    <= {N_EXT{1'b0}};
        end else begin
            state_r      <= state_nxt;
            // Lines acknowledged this cycle are consumed even if still high.
            pend_r       <= (pend_r | ext_int) & ~ext_ack_r;
            mca_r        <= mca_nxt;
            il_r         <= il_nxt;
            rpt_r        <= rpt_nxt;
            jisr_r       <= (state_nxt == ST_JISR);
            busy_r       <= (state_nxt == ST_RST) || (state_nxt == ST_JISR);
            in_handler_r <= (state_nxt == ST_HND);
            ext_ack_r    <= (state_nxt == ST_JISR) ? mca_nxt[N_INT-1:CAUSE_EXT0]
                                                   : {N_EXT{1'b0}};
        end
    end

    assign jisr        = jisr_r;
    assign mca         = mca_r;
    assign rpt         = rpt_r;
    assign il          = il_r;
    assign busy        = busy_r;
    assign in_handler  = in_handler_r;
    assign ext_ack     = ext_ack_r;
    assign redirect_pc = SISR_ADDR;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl. Every expected interrupt is pushed to a
// scoreboard when its stimulus is driven and popped when jisr appears.
module tb_int_ctrl;

    typedef struct {
        logic [22:0] mca;
        logic [4:0]  il;
        logic        rpt;
        logic [15:0] ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [5:0]  cause_int;
    logic        ovf;
    logic [15:0] ext_int;
    logic [22:0] sr;
    logic        rfe;
    logic        jisr;
    logic [22:0] mca;
    logic        rpt;
    logic [4:0]  il;
    logic        busy;
    logic        in_handler;
    logic [31:0] redirect_pc;
    logic [15:0] ext_ack;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    logic [22:0] rep_tb = 23'h00_0018;

    int_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .cause_int   (cause_int),
        .ovf         (ovf),
        .ext_int     (ext_int),
        .sr          (sr),
        .rfe         (rfe),
        .jisr        (jisr),
        .mca         (mca),
        .rpt         (rpt),
        .il          (il),
        .busy        (busy),
        .in_handler  (in_handler),
        .redirect_pc (redirect_pc),
        .ext_ack     (ext_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [22:0] m);
        exp_t e;
        e.mca = m;
        e.il  = 5'd0;
        for (int i = 22; i >= 0; i--) begin
            if (m[i]) e.il = 5'(i);
        end
        e.rpt = rep_tb[e.il];
        e.ack = m[22:7];
        return e;
    endfunction

    task automatic expect_irq(input logic [22:0] m);
        sb_q.push_back(make_exp(m));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        instr_valid = 1'b0;
        cause_int   = 6'd0;
        ovf         = 1'b0;
        ext_int     = 16'd0;
        rfe         = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_jisr"},    {31'd0, jisr},       32'd0);
        check_eq({pfx, "_mca"},     {9'd0, mca},         32'd0);
        check_eq({pfx, "_rpt"},     {31'd0, rpt},        32'd0);
        check_eq({pfx, "_il"},      {27'd0, il},         32'd0);
        check_eq({pfx, "_busy"},    {31'd0, busy},       32'd1);
        check_eq({pfx, "_inh"},     {31'd0, in_handler}, 32'd0);
        check_eq({pfx, "_ext_ack"}, {16'd0, ext_ack},    32'd0);
    endtask

    task automatic rfe_to_run(input string tag);
        instr_valid = 1'b1;
        rfe         = 1'b1;
        step();
        clear_in();
        check_eq(tag, {31'd0, in_handler}, 32'd0);
    endtask

    // Scoreboard: every jisr must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (jisr === 1'b1) begin
            check_eq("sb_has_entry", {31'd0, sb_q.size() > 0}, 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_mca",     {9'd0, mca},      {9'd0, e.mca});
                check_eq("sb_il",      {27'd0, il},      {27'd0, e.il});
                check_eq("sb_rpt",     {31'd0, rpt},     {31'd0, e.rpt});
                check_eq("sb_ext_ack", {16'd0, ext_ack}, {16'd0, e.ack});
                check_eq("sb_redir",   redirect_pc,      32'h0000_0000);
            end
        end
    end

    initial begin
        reset = 1'b1;
        sr    = 23'd0;
        clear_in();
        repeat (3) step();
        check_reset("rst1");

        // Reset interrupt after release.
        reset = 1'b0;
        expect_irq(23'h1);
        step();
        check_eq("rst_jisr", {31'd0, jisr}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        step();
        check_eq("rst_hnd_inh",  {31'd0, in_handler}, 32'd1);
        check_eq("rst_hnd_busy", {31'd0, busy},       32'd0);
        check_eq("rst_hnd_jisr", {31'd0, jisr},       32'd0);
        rfe_to_run("rfe_run1");

        // Page fault on fetch: repeat type, non-maskable.
        cause_int   = 6'b001000;
        instr_valid = 1'b1;
        expect_irq(23'h8);
        step();
        clear_in();
        check_eq("pff_lat", {31'd0, jisr}, 32'd1);
        step();
        check_eq("pff_inh", {31'd0, in_handler}, 32'd1);
        rfe_to_run("rfe_run2");

        // External line 7 masked: stays pending, no interrupt.
        ext_int = 16'h0001;
        step();
        ext_int = 16'h0000;
        step();
        check_eq("ext7_masked", {31'd0, jisr}, 32'd0);
        instr_valid = 1'b1;
        step();
        clear_in();
        check_eq("ext7_masked_iv", {31'd0, jisr}, 32'd0);

        // Unmask and take it at the next boundary.
        sr          = 23'h80;
        instr_valid = 1'b1;
        expect_irq(23'h80);
        step();
        clear_in();
        check_eq("ext7_jisr", {31'd0, jisr},    32'd1);
        check_eq("ext7_ack",  {16'd0, ext_ack}, 32'h1);
        step();
        // Pending must be gone, so rfe returns to user context.
        rfe_to_run("ext7_pend_clr");

        // Overflow plus external line 9, both unmasked.
        sr          = 23'h240;
        ovf         = 1'b1;
        ext_int     = 16'h0004;
        instr_valid = 1'b1;
        expect_irq(23'h240);
        step();
        clear_in();
        check_eq("ovf_jisr", {31'd0, jisr}, 32'd1);
        step();

        // rfe together with illegal instruction: interrupt wins.
        sr          = 23'd0;
        instr_valid = 1'b1;
        rfe         = 1'b1;
        cause_int   = 6'b000010;
        expect_irq(23'h2);
        step();
        clear_in();
        check_eq("rfe_ill_jisr", {31'd0, jisr}, 32'd1);
        check_eq("rfe_ill_busy", {31'd0, busy}, 32'd1);
        step();
        check_eq("rfe_ill_inh", {31'd0, in_handler}, 32'd1);

        // Nested multi-cause events: lowest index decides il and rpt.
        cause_int   = 6'b011100;
        instr_valid = 1'b1;
        expect_irq(23'h1C);
        step();
        clear_in();
        step();
        cause_int   = 6'b110000;
        instr_valid = 1'b1;
        expect_irq(23'h30);
        step();
        clear_in();
        step();
        rfe_to_run("rfe_run3");
        check_eq("mca_hold", {9'd0, mca},  32'h30);
        check_eq("il_hold",  {27'd0, il},  32'd4);
        check_eq("rpt_hold", {31'd0, rpt}, 32'd1);

        // Masked external pending is not reported with a trap.
        ext_int = 16'h8000;
        step();
        ext_int     = 16'h0000;
        cause_int   = 6'b100000;
        instr_valid = 1'b1;
        expect_irq(23'h20);
        step();
        clear_in();
        check_eq("trap_jisr", {31'd0, jisr}, 32'd1);
        step();
        check_eq("trap_inh", {31'd0, in_handler}, 32'd1);

        // Reset in the middle of the handler.
        reset = 1'b1;
        step();
        check_reset("rst2");
        reset = 1'b0;
        expect_irq(23'h1);
        step();
        check_eq("rst2_irq", {31'd0, jisr}, 32'd1);
        step();

        // Reset must have cleared the pending line 22.
        sr          = 23'h7F_FFFF;
        instr_valid = 1'b1;
        rfe         = 1'b1;
        step();
        clear_in();
        check_eq("pend_rst_clr", {31'd0, jisr},       32'd0);
        check_eq("pend_rst_inh", {31'd0, in_handler}, 32'd0);

        step();
        step();
        check_eq("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
